// File: rtl/fmap_unpad_pkg.sv
// Shared sizing helpers for the border pad/unpad stages.
// Both stages import this package so that P and the interior bounds are derived in one place.
package fmap_unpad_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FMAP_SIZE  = 28;
  localparam int DEF_N          = 1;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } fifo_occ_e;

  // Bits needed to count 0..value-1, never less than one.
  function automatic int clogb2(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        w = i + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

  function automatic int pad_side(input int fmap_size, input int n);
    return fmap_size + 2 * n;
  endfunction

  function automatic int interior_lo(input int n);
    return n;
  endfunction

  function automatic int interior_hi(input int fmap_size, input int n);
    return fmap_size + n - 1;
  endfunction

endpackage

// File: rtl/fmap_unpad_fifo.sv
// Two-entry registered stream FIFO; head register drives dout directly.
// Reused by other stream stages; srst flushes and has priority over push/pop.
module stream_fifo2
  import fmap_unpad_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  srst_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DATA_WIDTH-1:0] dout_o
);

  fifo_occ_e             occ_q, occ_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  assign full_o    = (occ_q == OCC_FULL);
  assign empty_o   = (occ_q == OCC_EMPTY);
  assign dout_o    = head_q;
  assign pop_ok_s  = pop_i & ~empty_o;
  assign push_ok_s = push_i & (~full_o | pop_i);

  // Next occupancy and storage contents.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    if (srst_i) begin
      occ_d = OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (push_ok_s) begin
            head_d = din_i;
            occ_d  = OCC_ONE;
          end else begin
            occ_d  = OCC_EMPTY;
          end
        end
        OCC_ONE: begin
          case ({push_ok_s, pop_ok_s})
            2'b10: begin
              tail_d = din_i;
              occ_d  = OCC_FULL;
            end
            2'b01: occ_d  = OCC_EMPTY;
            2'b11: head_d = din_i;
            default: occ_d = OCC_ONE;
          endcase
        end
        OCC_FULL: begin
          case ({push_ok_s, pop_ok_s})
            2'b01: begin
              head_d = tail_q;
              occ_d  = OCC_ONE;
            end
            2'b11: begin
              head_d = tail_q;
              tail_d = din_i;
            end
            default: occ_d = OCC_FULL;
          endcase
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= OCC_EMPTY;
      head_q <= {DATA_WIDTH{1'b0}};
      tail_q <= {DATA_WIDTH{1'b0}};
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule

// File: rtl/fmap_unpad.sv
// Strips an N-pixel border from a row-major padded feature-map stream and
// forwards the FMAP_SIZE x FMAP_SIZE interior on a valid/ready stream.
module fmap_unpad
  import fmap_unpad_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FMAP_SIZE  = DEF_FMAP_SIZE,
  parameter int N          = DEF_N
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  done
);

  localparam int P    = pad_side(FMAP_SIZE, N);
  localparam int RC_W = clogb2(P);
  localparam int OC_W = clogb2(FMAP_SIZE * FMAP_SIZE);

  localparam logic [RC_W-1:0] RC_LAST = RC_W'(P - 1);
  localparam logic [OC_W-1:0] OC_LAST = OC_W'(FMAP_SIZE * FMAP_SIZE - 1);

  logic [RC_W-1:0] row_q, row_d;
  logic [RC_W-1:0] col_q, col_d;
  logic [OC_W-1:0] out_cnt_q, out_cnt_d;
  logic            done_q, done_d;
  logic            buf_full_s;
  logic            buf_empty_s;
  logic            accept_s;
  logic            pop_s;
  logic            push_s;
  logic            row_in_s;
  logic            col_in_s;

  // With no border every pixel is interior; skip the always-true compares.
  generate
    if (N == 0) begin : g_no_border
      assign row_in_s = 1'b1;
      assign col_in_s = 1'b1;
    end else begin : g_border
      localparam logic [RC_W-1:0] RC_LO = RC_W'(interior_lo(N));
      localparam logic [RC_W-1:0] RC_HI = RC_W'(interior_hi(FMAP_SIZE, N));
      assign row_in_s = (row_q >= RC_LO) && (row_q <= RC_HI);
      assign col_in_s = (col_q >= RC_LO) && (col_q <= RC_HI);
    end
  endgenerate

  assign in_ready  = ena & ~buf_full_s;
  assign accept_s  = in_valid & in_ready;
  assign push_s    = accept_s & row_in_s & col_in_s;
  assign out_valid = ~buf_empty_s;
  assign pop_s     = out_valid & out_ready;
  assign done      = done_q;

  stream_fifo2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .srst_i  (clear),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .din_i   (in_data),
    .full_o  (buf_full_s),
    .empty_o (buf_empty_s),
    .dout_o  (out_data)
  );

  // Raster position of the next accepted padded pixel.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = {RC_W{1'b0}};
      col_d = {RC_W{1'b0}};
    end else if (accept_s) begin
      if (col_q == RC_LAST) begin
        col_d = {RC_W{1'b0}};
        if (row_q == RC_LAST) begin
          row_d = {RC_W{1'b0}};
        end else begin
          row_d = row_q + RC_W'(1);
        end
      end else begin
        col_d = col_q + RC_W'(1);
      end
    end else begin
      row_d = row_q;
      col_d = col_q;
    end
  end

  // Output handshake counter and end-of-map pulse.
  always_comb begin
    out_cnt_d = out_cnt_q;
    done_d    = 1'b0;
    if (clear) begin
      out_cnt_d = {OC_W{1'b0}};
      done_d    = 1'b0;
    end else if (pop_s) begin
      done_d = (out_cnt_q == OC_LAST);
      if (out_cnt_q == OC_LAST) begin
        out_cnt_d = {OC_W{1'b0}};
      end else begin
        out_cnt_d = out_cnt_q + OC_W'(1);
      end
    end else begin
      out_cnt_d = out_cnt_q;
      done_d    = 1'b0;
    end
  end

  // Counter and done registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q     <= {RC_W{1'b0}};
      col_q     <= {RC_W{1'b0}};
      out_cnt_q <= {OC_W{1'b0}};
      done_q    <= 1'b0;
    end else begin
      row_q     <= row_d;
      col_q     <= col_d;
      out_cnt_q <= out_cnt_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_fmap_unpad.sv
// Self-checking bench for fmap_unpad (FMAP_SIZE=4): dut_a uses N=1, dut_b uses N=0.
// Expected outputs come from a queue model driven by the interior rule.
module tb_fmap_unpad;

  localparam int DW = 16;
  localparam int FS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          ena_a, clear_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, done_a;
  logic [DW-1:0] in_data_a, out_data_a;
  logic          ena_b, clear_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, done_b;
  logic [DW-1:0] in_data_b, out_data_b;

  fmap_unpad #(.DATA_WIDTH(DW), .FMAP_SIZE(FS), .N(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena_a), .clear(clear_a),
    .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .done(done_a)
  );

  fmap_unpad #(.DATA_WIDTH(DW), .FMAP_SIZE(FS), .N(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena_b), .clear(clear_b),
    .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .done(done_b)
  );

  int total = 0;
  int bad   = 0;
  int sel   = 0;           // 0: dut_a (N=1), 1: dut_b (N=0)
  int m_idx [2];           // position within padded frame
  int m_dat [2];           // next input value
  int m_oc  [2];           // outputs taken within current map
  bit m_pend[2];           // done expected on the next cycle
  int exp_a[$];
  int exp_b[$];
  int n_acc, n_out, n_done;
  logic [DW-1:0] last_od;

  function automatic int side_len(input int s);
    return (s == 0) ? FS + 2 : FS;
  endfunction

  function automatic bit is_interior(input int s, input int k);
    int p, n, r, c;
    p = side_len(s);
    n = (s == 0) ? 1 : 0;
    r = k / p;
    c = k % p;
    return (r >= n) && (r < n + FS) && (c >= n) && (c < n + FS);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_idx[s] = 0; m_dat[s] = 0; m_oc[s] = 0; m_pend[s] = 1'b0;
    end
    exp_a.delete();
    exp_b.delete();
  endtask

  task automatic step(input bit iv, input bit ordy, input bit en, input bit clr);
    int   qsz, front, p;
    bit   exp_ir;
    logic ir, ov, dn;
    logic [DW-1:0] od;
    if (sel == 0) begin
      in_valid_a = iv; out_ready_a = ordy; ena_a = en; clear_a = clr;
      in_data_a = DW'(m_dat[0]);
      in_valid_b = 1'b0; out_ready_b = 1'b0; ena_b = 1'b1; clear_b = 1'b0;
    end else begin
      in_valid_b = iv; out_ready_b = ordy; ena_b = en; clear_b = clr;
      in_data_b = DW'(m_dat[1]);
      in_valid_a = 1'b0; out_ready_a = 1'b0; ena_a = 1'b1; clear_a = 1'b0;
    end
    @(negedge clk);
    ir = (sel == 0) ? in_ready_a  : in_ready_b;
    ov = (sel == 0) ? out_valid_a : out_valid_b;
    dn = (sel == 0) ? done_a      : done_b;
    od = (sel == 0) ? out_data_a  : out_data_b;
    if (sel == 0) last_od = od;
    qsz   = (sel == 0) ? exp_a.size() : exp_b.size();
    front = (qsz == 0) ? 0 : ((sel == 0) ? exp_a[0] : exp_b[0]);
    exp_ir = en && (qsz < 2);
    total++;
    if (ir !== exp_ir) begin
      bad++; $display("FAIL in_ready sel=%0d got=%b want=%b", sel, ir, exp_ir);
    end
    total++;
    if (ov !== (qsz > 0)) begin
      bad++; $display("FAIL out_valid sel=%0d got=%b want=%b", sel, ov, (qsz > 0));
    end
    if (qsz > 0) begin
      total++;
      if (od !== DW'(front)) begin
        bad++; $display("FAIL out_data sel=%0d got=%0d want=%0d", sel, od, front);
      end
    end
    total++;
    if (dn !== m_pend[sel]) begin
      bad++; $display("FAIL done sel=%0d got=%b want=%b", sel, dn, m_pend[sel]);
    end
    if (dn === 1'b1) n_done++;
    if (clr) begin
      if (sel == 0) exp_a.delete(); else exp_b.delete();
      m_idx[sel] = 0; m_dat[sel] = 0; m_oc[sel] = 0; m_pend[sel] = 1'b0;
    end else begin
      if (qsz > 0 && ordy) begin
        if (sel == 0) void'(exp_a.pop_front()); else void'(exp_b.pop_front());
        n_out++;
        m_pend[sel] = (m_oc[sel] == FS * FS - 1);
        m_oc[sel]   = (m_oc[sel] + 1) % (FS * FS);
      end else begin
        m_pend[sel] = 1'b0;
      end
      if (iv && exp_ir) begin
        p = side_len(sel);
        if (is_interior(sel, m_idx[sel])) begin
          if (sel == 0) exp_a.push_back(m_dat[sel]); else exp_b.push_back(m_dat[sel]);
        end
        m_dat[sel]++;
        m_idx[sel] = (m_idx[sel] + 1) % (p * p);
        n_acc++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_until(input int target, input bit ordy);
    int guard;
    guard = 0;
    while (n_acc < target && guard < 500) begin
      step(1'b1, ordy, 1'b1, 1'b0);
      guard++;
    end
    total++;
    if (n_acc != target) begin
      bad++; $display("FAIL accept_budget got=%0d want=%0d", n_acc, target);
    end
  endtask

  task automatic drain(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic check_counts(input string name, input int want_out, input int want_done);
    total++;
    if (n_out != want_out) begin
      bad++; $display("FAIL %s outputs got=%0d want=%0d", name, n_out, want_out);
    end
    total++;
    if (n_done != want_done) begin
      bad++; $display("FAIL %s done_pulses got=%0d want=%0d", name, n_done, want_done);
    end
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({out_valid_a, done_a, out_valid_b, done_b} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b want=0000", {out_valid_a, done_a, out_valid_b, done_b});
    end
    total++;
    if (out_data_a !== 16'd0 || out_data_b !== 16'd0) begin
      bad++; $display("FAIL reset_data got=%0d/%0d want=0", out_data_a, out_data_b);
    end
    total++;
    if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready got=%b%b want=11", in_ready_a, in_ready_b);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_stream();
    sel = 0; n_acc = 0; n_out = 0; n_done = 0;
    run_until(36, 1'b1);
    drain(6);
    check_counts("stream", 16, 1);
  endtask

  task automatic test_backpressure();
    sel = 0; n_acc = 0; n_out = 0; n_done = 0; m_dat[0] = 0;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    total++;
    if (n_acc != 9) begin
      bad++; $display("FAIL bp_accepts got=%0d want=9", n_acc);
    end
    total++;
    if (last_od !== 16'd7) begin
      bad++; $display("FAIL bp_hold got=%0d want=7", last_od);
    end
    run_until(36, 1'b1);
    drain(6);
    check_counts("backpressure", 16, 1);
  endtask

  task automatic test_clear();
    sel = 0; n_acc = 0; m_dat[0] = 0;
    run_until(20, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    n_acc = 0; n_out = 0; n_done = 0;
    run_until(36, 1'b1);
    drain(6);
    check_counts("clear", 16, 1);
  endtask

  task automatic test_passthrough();
    sel = 1; n_acc = 0; n_out = 0; n_done = 0; m_dat[1] = 0;
    run_until(16, 1'b1);
    drain(6);
    check_counts("passthrough", 16, 1);
    sel = 0;
  endtask

  task automatic test_reset_mid();
    sel = 0; n_acc = 0; m_dat[0] = 0;
    run_until(10, 1'b1);
    rst_n = 1'b0;
    #2;
    total++;
    if (out_valid_a !== 1'b0 || done_a !== 1'b0) begin
      bad++; $display("FAIL mid_reset got=%b%b want=00", out_valid_a, done_a);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    n_acc = 0; n_out = 0; n_done = 0;
    run_until(36, 1'b1);
    drain(6);
    check_counts("reset_mid", 16, 1);
  endtask

  task automatic test_back_to_back();
    int guard;
    sel = 0; n_acc = 0; n_out = 0; n_done = 0; m_dat[0] = 0;
    guard = 0;
    while (n_acc < 72 && guard < 3000) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'b0);
      guard++;
    end
    total++;
    if (n_acc != 72) begin
      bad++; $display("FAIL b2b_accepts got=%0d want=72", n_acc);
    end
    drain(8);
    check_counts("back_to_back", 32, 2);
  endtask

  initial begin
    rst_n = 1'b0;
    ena_a = 1'b1; clear_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b0; in_data_a = 16'd0;
    ena_b = 1'b1; clear_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b0; in_data_b = 16'd0;
    last_od = 16'd0;
    n_acc = 0; n_out = 0; n_done = 0;
    model_reset();
    #10;
    test_reset();
    test_stream();
    test_backpressure();
    test_clear();
    test_passthrough();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
